hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_pkg.sv | 26 ++
 rtl/hazard_stall_unit_muldiv_busy_fsm.sv | 69 ++++++
 rtl/hazard_stall_unit.sv | 97 +++++++++
 tb/tb_hazard_stall_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline package.
// Holds the read-register index type, the mult/div busy FSM state encoding,
// the default mult/div latency and the register-match helper used by the
// hazard comparators.
package hazard_stall_unit_pkg;

    // Register-file read/write index (5 bits, $0 is hard-wired zero)
    typedef logic [4:0] rreg_t;

    // Mult/div unit occupancy states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int unsigned MULDIV_LAT_DEFAULT = 32;
    localparam int unsigned MD_CNT_W           = 6;

    // A source only depends on a producer that really writes a register;
    // writes to $0 are discarded, so they never create a hazard.
    function automatic logic reg_match(input rreg_t x, input rreg_t w);
        return (w != '0) && (x == w);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_muldiv_busy_fsm.sv
// Mult/div occupancy tracker.
// Ports:
//   clk      in   pipeline clock (rising edge)
//   rst      in   asynchronous active-high reset
//   start_i  in   a mult/div instruction leaves ID this cycle
//   busy_o   out  unit is in BUSY (high for exactly MULDIV_LAT cycles)
module muldiv_busy_fsm
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MULDIV_LAT - 1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                busy_o = 1'b1;
                // Loaded with LAT-1 and leaving on zero gives LAT busy cycles
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MD_DONE: begin
                // Back-to-back issue skips the IDLE cycle
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detection and stall control.
// Detects load-use, load-to-branch and mult/div occupancy hazards, freezes
// PC and IF/ID while inserting a bubble into ID/EXE, squashes IF/ID on a
// taken branch, and counts stalled cycles.
// Ports:
//   clk, rst                         clock, async active-high reset
//   id_rs, id_rt, id_use_rs/rt       ID source registers and use flags
//   id_branch, id_branch_taken       ID compares operands / branch taken
//   id_muldiv, id_hilo_rd            ID is mult/div, ID is mfhi/mflo
//   ex_wreg/ex_regwrite/ex_memread   ID/EXE producer info
//   mem_wreg/mem_regwrite/mem_memread EXE/MEM producer info
//   pc_we, if_id_we, id_ex_bubble    stall controls
//   if_id_flush                      squash IF/ID
//   muldiv_busy                      mult/div unit busy
//   stall_cycles                     saturating stalled-cycle counter
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_branch,
    input  logic        id_branch_taken,
    input  logic        id_muldiv,
    input  logic        id_hilo_rd,
    input  logic [4:0]  ex_wreg,
    input  logic [4:0]  mem_wreg,
    input  logic        ex_regwrite,
    input  logic        mem_regwrite,
    input  logic        ex_memread,
    input  logic        mem_memread,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        muldiv_busy,
    output logic [31:0] stall_cycles
);

    logic        load_use;
    logic        br_load;
    logic        md_stall;
    logic        stall;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        load_use = ex_memread & ex_regwrite &
                   ((id_use_rs & reg_match(id_rs, ex_wreg)) |
                    (id_use_rt & reg_match(id_rt, ex_wreg)));
        // ALU results in EXE/MEM are forwarded to the ID comparator; load
        // data is not, so only a load there holds a branch.
        br_load  = id_branch & mem_memread & mem_regwrite &
                   ((id_use_rs & reg_match(id_rs, mem_wreg)) |
                    (id_use_rt & reg_match(id_rt, mem_wreg)));
        md_stall = muldiv_busy & (id_muldiv | id_hilo_rd);
        // Outputs are forced to their idle values while reset is held
        stall    = ~rst & (load_use | br_load | md_stall);

        pc_we        = ~stall;
        if_id_we     = ~stall;
        id_ex_bubble = stall;
        // A stalled branch is re-evaluated next cycle, so no flush yet
        if_id_flush  = ~rst & id_branch_taken & ~stall;
    end

    muldiv_busy_fsm #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_busy_fsm (
        .clk     (clk),
        .rst     (rst),
        .start_i (id_muldiv & ~stall),
        .busy_o  (muldiv_busy)
    );

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg;
    logic        id_use_rs, id_use_rt, id_branch, id_branch_taken;
    logic        id_muldiv, id_hilo_rd;
    logic        ex_regwrite, mem_regwrite, ex_memread, mem_memread;
    logic        pc_we, if_id_we, id_ex_bubble, if_id_flush, muldiv_busy;
    logic [31:0] stall_cycles;

    hazard_stall_unit #(
        .MULDIV_LAT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_branch       (id_branch),
        .id_branch_taken (id_branch_taken),
        .id_muldiv       (id_muldiv),
        .id_hilo_rd      (id_hilo_rd),
        .ex_wreg         (ex_wreg),
        .mem_wreg        (mem_wreg),
        .ex_regwrite     (ex_regwrite),
        .mem_regwrite    (mem_regwrite),
        .ex_memread      (ex_memread),
        .mem_memread     (mem_memread),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .muldiv_busy     (muldiv_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_we;
        logic        if_id_we;
        logic        bubble;
        logic        flush;
        logic        busy;
        logic [31:0] cycles;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_cycles = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_wreg = '0; mem_wreg = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_branch = 1'b0; id_branch_taken = 1'b0;
        id_muldiv = 1'b0; id_hilo_rd = 1'b0;
        ex_regwrite = 1'b0; mem_regwrite = 1'b0;
        ex_memread = 1'b0; mem_memread = 1'b0;
    endtask

    // Push expectation for the inputs just driven, let them settle, then
    // pop and compare; the counter model advances at the coming edge.
    task automatic tick(input string tag, input logic e_stall, input logic e_flush, input logic e_busy);
        exp_t  e;
        string t;
        e.pc_we    = ~e_stall;
        e.if_id_we = ~e_stall;
        e.bubble   = e_stall;
        e.flush    = e_flush;
        e.busy     = e_busy;
        e.cycles   = model_cycles;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".pc_we"},        32'(pc_we),        32'(e.pc_we));
        chk({t, ".if_id_we"},     32'(if_id_we),     32'(e.if_id_we));
        chk({t, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e.bubble));
        chk({t, ".if_id_flush"},  32'(if_id_flush),  32'(e.flush));
        chk({t, ".muldiv_busy"},  32'(muldiv_busy),  32'(e.busy));
        chk({t, ".stall_cycles"}, stall_cycles,      e.cycles);
        if (e_stall && model_cycles != 32'hFFFF_FFFF) model_cycles = model_cycles + 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with hazard-producing inputs present
        clear_inputs();
        rst = 1'b1;
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
        id_branch_taken = 1'b1; id_muldiv = 1'b1;
        @(negedge clk); tick("rst0", 0, 0, 0);
        @(negedge clk); tick("rst1", 0, 0, 0);
        @(negedge clk); rst = 1'b0; clear_inputs(); tick("idle", 0, 0, 0);

        // lw $8 in EXE, add uses $8
        @(negedge clk); clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
        tick("load_use_rs", 1, 0, 0);
        @(negedge clk); clear_inputs();
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wreg = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
        tick("load_use_after", 0, 0, 0);

        // $0 never hazards
        @(negedge clk); clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd0;
        id_rs = 5'd0; id_use_rs = 1'b1;
        tick("load_r0", 0, 0, 0);

        // Matching rs not actually read
        @(negedge clk); clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd12;
        id_rs = 5'd12; id_use_rs = 1'b0;
        tick("rs_unused", 0, 0, 0);

        // rt dependency
        @(negedge clk); clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd17;
        id_rt = 5'd17; id_use_rt = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
        tick("load_use_rt", 1, 0, 0);

        // ALU result in EXE is not a hazard
        @(negedge clk); clear_inputs();
        ex_regwrite = 1'b1; ex_wreg = 5'd17;
        id_rt = 5'd17; id_use_rt = 1'b1;
        tick("alu_ex", 0, 0, 0);

        // lw $9 ; beq $9,$9 taken: two stalls then flush
        @(negedge clk); clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9;
        id_rs = 5'd9; id_rt = 5'd9; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_branch = 1'b1; id_branch_taken = 1'b1;
        tick("br_stall1", 1, 0, 0);
        @(negedge clk); clear_inputs();
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wreg = 5'd9;
        id_rs = 5'd9; id_rt = 5'd9; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_branch = 1'b1; id_branch_taken = 1'b1;
        tick("br_stall2", 1, 0, 0);
        @(negedge clk); clear_inputs();
        id_rs = 5'd9; id_rt = 5'd9; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_branch = 1'b1; id_branch_taken = 1'b1;
        tick("br_flush", 0, 1, 0);

        // ALU result in EXE/MEM feeding a branch is forwarded
        @(negedge clk); clear_inputs();
        mem_regwrite = 1'b1; mem_wreg = 5'd5;
        id_rs = 5'd5; id_use_rs = 1'b1; id_branch = 1'b1;
        tick("br_alu_mem", 0, 0, 0);

        // Stalled mult must not start the unit
        @(negedge clk); clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd4;
        id_rs = 5'd4; id_use_rs = 1'b1; id_muldiv = 1'b1;
        tick("mult_stalled", 1, 0, 0);
        @(negedge clk); clear_inputs();
        tick("mult_not_started", 0, 0, 0);

        // mult then mfhi: four busy cycles, mfhi proceeds in DONE
        @(negedge clk); clear_inputs(); id_muldiv = 1'b1;
        tick("mult_issue", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clear_inputs(); id_hilo_rd = 1'b1;
            tick("mfhi_wait", 1, 0, 1);
        end
        @(negedge clk); clear_inputs(); id_hilo_rd = 1'b1;
        tick("mfhi_go", 0, 0, 0);
        @(negedge clk); clear_inputs();
        tick("md_idle", 0, 0, 0);

        // Back-to-back mult issued from DONE
        @(negedge clk); clear_inputs(); id_muldiv = 1'b1;
        tick("b2b_first", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clear_inputs(); id_muldiv = 1'b1;
            tick("b2b_wait", 1, 0, 1);
        end
        @(negedge clk); clear_inputs(); id_muldiv = 1'b1;
        tick("b2b_issue", 0, 0, 0);
        @(negedge clk); clear_inputs();
        tick("b2b_busy1", 0, 0, 1);

        // Asynchronous reset on BUSY cycle 2
        @(negedge clk); clear_inputs(); id_hilo_rd = 1'b1;
        rst = 1'b1;
        model_cycles = '0;
        tick("rst_mid_busy", 0, 0, 0);
        #1 rst = 1'b0;
        @(negedge clk); clear_inputs(); id_hilo_rd = 1'b1;
        tick("post_rst_mfhi", 0, 0, 0);
        @(negedge clk); clear_inputs();
        tick("post_rst_idle", 0, 0, 0);

        // Counter saturation
        @(negedge clk);
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1 release dut.stall_cycles_q;
        model_cycles = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clear_inputs();
            ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd20;
            id_rs = 5'd20; id_use_rs = 1'b1;
            tick("sat_stall", 1, 0, 0);
        end
        @(negedge clk); clear_inputs();
        tick("sat_hold", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
